// File: rtl/des_reg_slice_if.sv
// Valid/ready word stream used on both sides of des_reg_slice.
// A beat transfers on a rising edge where valid & ready are both high; data is
// held stable by the master while valid is high and ready is low.
interface des_reg_slice_if #(
  parameter int WIDTH = 64
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/des_reg_slice.sv
// Fully registered two-entry skid slice for the TDES datapath, with sync flush.
// Optional per-byte DES odd-parity tagging when DES_REG_SLICE_PARITY_EN is defined.
module des_reg_slice #(
  parameter int WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  des_reg_slice_if.slave        s,
  des_reg_slice_if.master       m,
`ifdef DES_REG_SLICE_PARITY_EN
  output logic                  m_par_err,
`endif
  output logic [1:0]            level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             s_ready_q, m_valid_q;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             accept, emit;
  logic             ld_main_in, ld_skid, ld_main_skid;

  assign accept  = s.valid & s_ready_q;
  assign emit    = m_valid_q & m.ready;
  assign s.ready = s_ready_q;
  assign m.valid = m_valid_q;
  assign m.data  = main_q;
  assign level   = state_q;

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_skid      = 1'b0;
    ld_main_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          ld_main_in = 1'b1;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (accept && emit) begin
          ld_main_in = 1'b1;
        end else if (accept) begin
          ld_skid = 1'b1;
          state_d = TWO;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (emit) begin
          ld_main_skid = 1'b1;
          state_d      = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Handshake flags are re-derived from the next state so they stay pure flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      state_q   <= EMPTY;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d != TWO);
      m_valid_q <= (state_d != EMPTY);
      if (ld_main_in)        main_q <= s.data;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= s.data;
    end
  end

`ifdef DES_REG_SLICE_PARITY_EN
  if (WIDTH % 8 != 0) begin : g_width_check
    $error("des_reg_slice: WIDTH must be a multiple of 8 with parity checking");
  end

  // A DES key byte is valid only with an odd number of ones.
  function automatic logic par_violation(input logic [WIDTH-1:0] d);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < WIDTH / 8; i++) begin
      bad = bad | ~(^d[8*i +: 8]);
    end
    return bad;
  endfunction

  logic main_tag_q, skid_tag_q, in_tag;
  assign in_tag    = par_violation(s.data);
  assign m_par_err = main_tag_q & m_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_tag_q <= 1'b0;
      skid_tag_q <= 1'b0;
    end else if (flush) begin
      main_tag_q <= 1'b0;
      skid_tag_q <= 1'b0;
    end else begin
      if (ld_main_in)        main_tag_q <= in_tag;
      else if (ld_main_skid) main_tag_q <= skid_tag_q;
      if (ld_skid)           skid_tag_q <= in_tag;
    end
  end
`endif

endmodule

// File: doc/des_reg_slice.md
# des_reg_slice

Parametrised, fully registered pipeline slice for the TDES datapath, replacing fixed-width bare registers between cipher rounds and key-schedule stages. Carries a WIDTH-bit word over a valid/ready handshake with a two-entry skid buffer, so throughput stays at one beat per cycle while every output, including upstream ready, comes from a flop. Supports synchronous flush and optional per-byte DES odd-parity checking.

## Interface
Parameters:
- WIDTH, 64, data width in bits; must be a multiple of 8 when DES_REG_SLICE_PARITY_EN is defined.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high
- flush  input  1  synchronous clear of contents; priority over all traffic
- s_valid  input  1  upstream word valid
- s_ready  output  1  slice can accept a word; registered
- s_data  input  WIDTH  upstream word
- m_valid  output  1  downstream word valid; registered
- m_ready  input  1  downstream accepts
- m_data  output  WIDTH  downstream word; registered
- m_par_err  output  1  parity error tag of current m_data (only with DES_REG_SLICE_PARITY_EN)
- level  output  2  occupancy 0..2; registered

## Operation
- Storage: main register (drives m_data) and skid register, each WIDTH bits plus a tag bit when parity is enabled.
- Accept = s_valid & s_ready. Emit = m_valid & m_ready.
- State machine, encoded in level:
  - EMPTY (0): accept -> main <= s_data, go ONE.
  - ONE (1): accept & emit -> main <= s_data, stay ONE. Accept only -> skid <= s_data, go TWO. Emit only -> go EMPTY.
  - TWO (2): s_ready = 0, so no accept. Emit -> main <= skid, go ONE.
- Derived registered outputs: m_valid = (level != 0), s_ready = (level != 2).
- Order preserved strictly; no word dropped or duplicated.
- Flush: next edge forces EMPTY, main and skid cleared to 0, s_ready = 1, m_valid = 0. Words offered or pending that cycle are discarded. Flush with s_valid: input word is not captured.
- m_data holds its value while m_valid & !m_ready (stable under backpressure). Contents of main when EMPTY are don't-care, except 0 after reset or flush.

## Timing
- Reset (asynchronous assert): level = 0, m_valid = 0, s_ready = 1, m_data = 0, m_par_err = 0, skid = 0.
- Latency: word accepted at edge N appears on m_data/m_valid after edge N (1 cycle) if main is free, otherwise once preceding words drain.
- Sustained throughput: 1 word/cycle with m_ready held high.
- Backpressure: after m_ready drops, slice absorbs at most one further word (into skid), then s_ready falls at the next edge.
- Release from TWO: s_ready returns high one edge after the first emit.
- Reset mid-transfer: all contents discarded immediately; no partial beat emitted after deassertion.

## Configuration
- DES_REG_SLICE_PARITY_EN defined: on accept, compute per byte of s_data the XOR of its 8 bits; tag = 1 if any byte has even parity (DES odd-parity violation). Tag travels with the word through main/skid; m_par_err presents it alongside m_data, qualified by m_valid. Tag cleared by reset/flush. Data path is unaffected (word still forwarded).
- Not defined: m_par_err port and tag storage absent; all other behaviour identical.

## Test plan
- Reset then single word: s_data = 64'h0123456789ABCDEF, s_valid one cycle, m_ready = 1 -> m_valid high exactly one cycle after accept, m_data = 64'h0123456789ABCDEF, level 0->1->0.
- Streaming: 16 consecutive words 0..15, s_valid and m_ready held high -> output 0..15 in order on consecutive cycles, s_ready never low, level stays 1.
- Backpressure: stream words while m_ready = 0 -> two words accepted, s_ready low from the following edge, level = 2; raise m_ready -> both words emitted in order, s_ready high one edge after first emit.
- Flush at level 2 with s_valid high -> next cycle level = 0, m_valid = 0, m_data = 0, s_ready = 1; the offered word never appears at output.
- Async reset asserted mid-stream at level 2 -> outputs reach reset values immediately without a clock edge; after release, first new word passes intact.
- With DES_REG_SLICE_PARITY_EN: send 64'h0101010101010101 -> m_par_err = 0; send 64'h0101010101010100 -> m_par_err = 1 on that word only, next word clean -> 0.
